// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity modes,
// FIFO entry layout and the sample vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Entry layout: {break, frame_err, parity_err, data[7:0]}
  localparam int unsigned ENTRY_W        = 11;
  localparam int unsigned ENTRY_DATA_LSB = 0;
  localparam int unsigned ENTRY_PERR_BIT = 8;
  localparam int unsigned ENTRY_FERR_BIT = 9;
  localparam int unsigned ENTRY_BRK_BIT  = 10;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; head is valid
// combinationally whenever the FIFO is not empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   level
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: input sync, tick generator, 3-sample majority vote, frame FSM
// with run-time line format, error tagging and an integrated RX FIFO.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter int unsigned FIFO_ADDR_BITS = 4
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [DIV_WIDTH-1:0]      cfg_divisor,
  input  logic [1:0]                cfg_bitsize,
  input  logic [1:0]                cfg_parity,
  input  logic                      cfg_stopbits,
  input  logic                      rx,
  output logic [7:0]                rx_data,
  output logic                      rx_parity_err,
  output logic                      rx_frame_err,
  output logic                      rx_break,
  output logic                      rx_valid,
  input  logic                      rx_accept,
  output logic                      rx_overrun,
  input  logic                      overrun_clr,
  output logic [FIFO_ADDR_BITS:0]   fifo_level,
  output logic                      rx_busy
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID  = OVERSAMPLE / 2;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] SAMP_A  = OS_W'(MID - 1);
  localparam logic [OS_W-1:0] SAMP_B  = OS_W'(MID);
  localparam logic [OS_W-1:0] SAMP_C  = OS_W'(MID + 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_last;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_cur;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic                 vote_now;

  rx_state_t            state;
  rx_state_t            state_nx;
  logic                 start_det;
  logic                 frame_done;
  logic                 brk_now;
  logic                 par_en;

  logic [2:0]           bit_idx;
  logic [7:0]           data_sr;
  logic                 par_bit;
  logic                 perr;
  logic [2:0]           f_last_bit;
  logic [1:0]           f_par;
  logic                 f_stop2;

  logic [ENTRY_W-1:0]   entry_q;
  logic                 push_q;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;

  assign tick      = (div_cnt == div_cur);
  assign start_det = (state == ST_IDLE) && rx_last && !rx_s;
  assign vote      = maj3(samp_a, samp_b, rx_s);
  assign vote_now  = tick && (state != ST_IDLE) && (os_cnt == SAMP_C);
  assign par_en    = (f_par == PAR_ODD) || (f_par == PAR_EVEN);
  assign brk_now   = (state == ST_STOP1) && !vote && (data_sr == '0) && !(par_en && par_bit);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (start_det) state_nx = ST_START;
      ST_START:  if (vote_now) state_nx = vote ? ST_IDLE : ST_DATA;
      ST_DATA:   if (vote_now && (bit_idx == f_last_bit)) state_nx = par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (vote_now) state_nx = ST_STOP1;
      ST_STOP1: begin
        // A bad first stop bit ends the frame; the second is never sampled.
        if (vote_now) begin
          if (vote && f_stop2) begin
            state_nx = ST_STOP2;
          end else begin
            state_nx   = ST_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (vote_now) begin
          state_nx   = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_last    <= 1'b1;
      div_cnt    <= '0;
      div_cur    <= '0;
      os_cnt     <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      bit_idx    <= '0;
      data_sr    <= '0;
      par_bit    <= 1'b0;
      perr       <= 1'b0;
      f_last_bit <= '0;
      f_par      <= PAR_NONE;
      f_stop2    <= 1'b0;
      entry_q    <= '0;
      push_q     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_last <= rx_s;
      push_q  <= frame_done;

      // Start detection realigns the tick phase to the falling edge.
      if (start_det || tick) begin
        div_cnt <= '0;
        div_cur <= cfg_divisor;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (start_det) begin
        os_cnt     <= '0;
        bit_idx    <= '0;
        data_sr    <= '0;
        par_bit    <= 1'b0;
        perr       <= 1'b0;
        f_last_bit <= 3'd4 + {1'b0, cfg_bitsize};
        f_par      <= cfg_parity;
        f_stop2    <= cfg_stopbits;
      end else if (tick && (state != ST_IDLE)) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (os_cnt == SAMP_A) samp_a <= rx_s;
        if (os_cnt == SAMP_B) samp_b <= rx_s;
      end

      if (vote_now) begin
        case (state)
          ST_DATA: begin
            data_sr[bit_idx] <= vote;
            bit_idx          <= bit_idx + 1'b1;
          end
          ST_PARITY: begin
            par_bit <= vote;
            perr    <= (f_par == PAR_ODD) ? ~(^data_sr ^ vote) : (^data_sr ^ vote);
          end
          default: ;
        endcase
      end

      if (frame_done) begin
        entry_q <= {brk_now, !vote, perr, data_sr};
      end
    end
  end

  assign pop = rx_accept && rx_valid;

  uart_sync_fifo #(
    .WIDTH     (ENTRY_W),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (reset),
    .push  (push_q),
    .din   (entry_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_overrun <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      rx_overrun <= 1'b1;
    end else if (overrun_clr) begin
      rx_overrun <= 1'b0;
    end
  end

  assign rx_data       = fifo_dout[ENTRY_DATA_LSB +: 8];
  assign rx_parity_err = fifo_dout[ENTRY_PERR_BIT];
  assign rx_frame_err  = fifo_dout[ENTRY_FERR_BIT];
  assign rx_break      = fifo_dout[ENTRY_BRK_BIT];
  assign rx_valid      = !fifo_empty;
  assign rx_busy       = (state != ST_IDLE);

endmodule
